// File: rtl/wb_stage.sv
// wb_stage: writeback stage and commit point of the pipeline.
//   Latches the memory-stage bus, writes the register file with per-byte
//   enables, holds the CP0 subset (BadVAddr, Count, Compare, Status, Cause,
//   EPC) and raises the pipeline-wide flush on exception or ERET.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   ms_to_ws_valid / ms_to_ws_bus    instruction from the memory stage
//   ws_allowin                       this stage can accept (always 1)
//   ext_int_in[5:0]                  hardware interrupt lines
//   rf_we / rf_waddr / rf_wdata      register file write port
//   ws_fwd_bus                       {mfc0_valid, rf_we, dest, wdata} to decode
//   flush / flush_pc                 redirect of all earlier stages
//   has_int                          pending enabled interrupt
//   debug_wb_*                       commit trace
module wb_stage #(
  parameter logic [31:0] EX_VECTOR = 32'hBFC00380,
  parameter int          MS_WS_WD  = 123
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ms_to_ws_valid,
  input  logic [MS_WS_WD-1:0] ms_to_ws_bus,
  output logic                ws_allowin,
  input  logic [5:0]          ext_int_in,
  output logic [3:0]          rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [41:0]         ws_fwd_bus,
  output logic                flush,
  output logic [31:0]         flush_pc,
  output logic                has_int,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_wen,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata
);

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  logic                ws_valid_q, ws_valid_d;
  logic [MS_WS_WD-1:0] bus_q, bus_d;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic        tick_q, tick_d;
  logic [31:0] compare_q, compare_d;
  logic [7:0]  status_im_q, status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q, status_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic        cause_ti_q, cause_ti_d;
  logic [5:0]  cause_ip_hw_q, cause_ip_hw_d;
  logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
  logic [4:0]  cause_exccode_q, cause_exccode_d;
  logic [31:0] epc_q, epc_d;

  // Fields of the latched bus
  logic [31:0] ws_badvaddr, ws_result, ws_pc;
  logic        ws_eret_bit, ws_mtc0_bit, ws_mfc0_bit, ws_bd, ws_ex_bit;
  logic [4:0]  ws_cp0_rd, ws_excode, ws_dest;
  logic [2:0]  ws_cp0_sel;
  logic [3:0]  ws_rf_we;

  assign ws_badvaddr = bus_q[122:91];
  assign ws_eret_bit = bus_q[90];
  assign ws_mtc0_bit = bus_q[89];
  assign ws_mfc0_bit = bus_q[88];
  assign ws_cp0_rd   = bus_q[87:83];
  assign ws_cp0_sel  = bus_q[82:80];
  assign ws_bd       = bus_q[79];
  assign ws_ex_bit   = bus_q[78];
  assign ws_excode   = bus_q[77:73];
  assign ws_rf_we    = bus_q[72:69];
  assign ws_dest     = bus_q[68:64];
  assign ws_result   = bus_q[63:32];
  assign ws_pc       = bus_q[31:0];

  logic        ws_ex, ws_eret, mtc0_we;
  logic [7:0]  cause_ip;
  logic [31:0] status_val, cause_val, cp0_rdata;

  assign ws_ex   = ws_valid_q && ws_ex_bit;
  assign ws_eret = ws_valid_q && ws_eret_bit && !ws_ex_bit;
  // Non-zero sel addresses nothing in this CP0 subset
  assign mtc0_we = ws_valid_q && ws_mtc0_bit && !ws_ex_bit && (ws_cp0_sel == 3'd0);

  // The timer interrupt shares IP[7] with the top hardware line
  assign cause_ip   = {cause_ip_hw_q[5] | cause_ti_q, cause_ip_hw_q[4:0], cause_ip_sw_q};
  assign status_val = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
  assign cause_val  = {cause_bd_q, cause_ti_q, 14'd0, cause_ip, 1'b0, cause_exccode_q, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    if (ws_cp0_sel == 3'd0) begin
      case (ws_cp0_rd)
        CP0_BADVADDR: cp0_rdata = badvaddr_q;
        CP0_COUNT:    cp0_rdata = count_q;
        CP0_COMPARE:  cp0_rdata = compare_q;
        CP0_STATUS:   cp0_rdata = status_val;
        CP0_CAUSE:    cp0_rdata = cause_val;
        CP0_EPC:      cp0_rdata = epc_q;
        default:      cp0_rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    ws_valid_d      = (ws_ex || ws_eret) ? 1'b0 : ms_to_ws_valid;
    bus_d           = ms_to_ws_valid ? ms_to_ws_bus : bus_q;
    badvaddr_d      = badvaddr_q;
    tick_d          = ~tick_q;
    count_d         = count_q + {31'd0, tick_q};
    compare_d       = compare_q;
    status_im_d     = status_im_q;
    status_exl_d    = status_exl_q;
    status_ie_d     = status_ie_q;
    cause_bd_d      = cause_bd_q;
    cause_ti_d      = cause_ti_q;
    cause_ip_hw_d   = ext_int_in;
    cause_ip_sw_d   = cause_ip_sw_q;
    cause_exccode_d = cause_exccode_q;
    epc_d           = epc_q;

    if (mtc0_we) begin
      case (ws_cp0_rd)
        CP0_COUNT:   count_d   = ws_result;
        CP0_COMPARE: compare_d = ws_result;
        CP0_STATUS: begin
          status_im_d  = ws_result[15:8];
          status_exl_d = ws_result[1];
          status_ie_d  = ws_result[0];
        end
        CP0_CAUSE:   cause_ip_sw_d = ws_result[9:8];
        CP0_EPC:     epc_d         = ws_result;
        default: ;
      endcase
    end

    // Match uses the post-update values; a Compare write in the same cycle wins
    if (count_d == compare_d) cause_ti_d = 1'b1;
    if (mtc0_we && ws_cp0_rd == CP0_COMPARE) cause_ti_d = 1'b0;

    if (ws_ex) begin
      status_exl_d    = 1'b1;
      cause_exccode_d = ws_excode;
      if (ws_excode == 5'h04 || ws_excode == 5'h05) badvaddr_d = ws_badvaddr;
      // Nested exceptions keep the original return point
      if (!status_exl_q) begin
        cause_bd_d = ws_bd;
        epc_d      = ws_bd ? ws_pc - 32'd4 : ws_pc;
      end
    end else if (ws_eret) begin
      status_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q      <= 1'b0;
      bus_q           <= '0;
      badvaddr_q      <= 32'd0;
      count_q         <= 32'd0;
      tick_q          <= 1'b0;
      compare_q       <= 32'd0;
      status_im_q     <= 8'd0;
      status_exl_q    <= 1'b0;
      status_ie_q     <= 1'b0;
      cause_bd_q      <= 1'b0;
      cause_ti_q      <= 1'b0;
      cause_ip_hw_q   <= 6'd0;
      cause_ip_sw_q   <= 2'd0;
      cause_exccode_q <= 5'd0;
      epc_q           <= 32'd0;
    end else begin
      ws_valid_q      <= ws_valid_d;
      bus_q           <= bus_d;
      badvaddr_q      <= badvaddr_d;
      count_q         <= count_d;
      tick_q          <= tick_d;
      compare_q       <= compare_d;
      status_im_q     <= status_im_d;
      status_exl_q    <= status_exl_d;
      status_ie_q     <= status_ie_d;
      cause_bd_q      <= cause_bd_d;
      cause_ti_q      <= cause_ti_d;
      cause_ip_hw_q   <= cause_ip_hw_d;
      cause_ip_sw_q   <= cause_ip_sw_d;
      cause_exccode_q <= cause_exccode_d;
      epc_q           <= epc_d;
    end
  end

  // Outputs
  assign ws_allowin = 1'b1;
  assign rf_we      = {4{ws_valid_q && !ws_ex}} & ws_rf_we;
  assign rf_waddr   = ws_valid_q ? ws_dest : 5'd0;
  assign rf_wdata   = !ws_valid_q ? 32'd0 : (ws_mfc0_bit ? cp0_rdata : ws_result);
  assign ws_fwd_bus = {ws_valid_q && ws_mfc0_bit, rf_we, rf_waddr, rf_wdata};
  assign flush      = ws_ex || ws_eret;
  assign flush_pc   = !ws_valid_q ? 32'd0 : (ws_ex ? EX_VECTOR : epc_q);
  assign has_int    = ((cause_ip & status_im_q) != 8'd0) && status_ie_q && !status_exl_q;

  assign debug_wb_pc       = ws_valid_q ? ws_pc : 32'd0;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of wb_stage through its commit, forwarding,
// flush and mfc0-readback behaviour.
module tb_wb_stage;

  logic         clk;
  logic         resetn;
  logic         ms_to_ws_valid;
  logic [122:0] ms_to_ws_bus;
  logic         ws_allowin;
  logic [5:0]   ext_int_in;
  logic [3:0]   rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [41:0]  ws_fwd_bus;
  logic         flush;
  logic [31:0]  flush_pc;
  logic         has_int;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .ext_int_in        (ext_int_in),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_bus        (ws_fwd_bus),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .has_int           (has_int),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [122:0] bus;
    logic [3:0]   we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         fl;
    logic [31:0]  fpc;
    logic         mf;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  localparam logic [10:0] NOC0  = 11'd0;
  localparam logic [10:0] ERET  = 11'b100_00000_000;

  function automatic logic [10:0] mfc0(input logic [4:0] rd, input logic [2:0] sel);
    return {3'b001, rd, sel};
  endfunction

  function automatic logic [10:0] mtc0(input logic [4:0] rd);
    return {3'b010, rd, 3'd0};
  endfunction

  function automatic logic [122:0] mk(input logic [31:0] bad, input logic [10:0] c0,
                                      input logic bd, input logic ex, input logic [4:0] exc,
                                      input logic [3:0] we, input logic [4:0] dest,
                                      input logic [31:0] res, input logic [31:0] pc);
    return {bad, c0, bd, ex, exc, we, dest, res, pc};
  endfunction

  function automatic vec_t mv(input logic [122:0] bus, input logic [3:0] we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic fl, input logic [31:0] fpc,
                              input logic mf);
    vec_t v;
    v.bus = bus; v.we = we; v.waddr = wa; v.wdata = wd; v.fl = fl; v.fpc = fpc; v.mf = mf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end else begin
      $display("ok   %s[%0d] = %h", nm, idx, act);
    end
  endtask

  // Present one instruction; returns #1 after it entered WB
  task automatic apply(input logic [122:0] bus);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = bus;
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Commit an mtc0, then the extra edge that writes CP0
  task automatic do_mtc0(input logic [4:0] rd, input logic [31:0] val);
    apply(mk(32'd0, mtc0(rd), 1'b0, 1'b0, 5'd0, 4'h0, 5'd0, val, 32'hBFC0_1000));
    idle(1);
  endtask

  // Read a CP0 register through an mfc0 commit
  task automatic rd_cp0(input logic [4:0] rd, output logic [31:0] val);
    apply(mk(32'd0, mfc0(rd, 3'd0), 1'b0, 1'b0, 5'd0, 4'hF, 5'd1, 32'd0, 32'hBFC0_2000));
    val = rf_wdata;
    idle(1);
  endtask

  initial begin
    logic [31:0] v32;
    int n;

    // idx bus                                                                      we    wa     wdata         fl    fpc           mf
    vt[0]  = mv(mk(0, NOC0, 0, 0, 0, 4'hF, 5, 32'h1234_5678, 32'hBFC0_0000),        4'hF, 5,     32'h1234_5678, 0, 0,             0);
    vt[1]  = mv(mk(0, NOC0, 0, 0, 0, 4'hC, 6, 32'hAABB_CCDD, 32'hBFC0_0004),        4'hC, 6,     32'hAABB_CCDD, 0, 0,             0);
    vt[2]  = mv(mk(0, NOC0, 0, 0, 0, 4'h3, 7, 32'h1122_3344, 32'hBFC0_0008),        4'h3, 7,     32'h1122_3344, 0, 0,             0);
    vt[3]  = mv(mk(0, mtc0(14), 0, 0, 0, 4'h0, 0, 32'h8000_0010, 32'hBFC0_000C),    4'h0, 0,     32'h8000_0010, 0, 0,             0);
    vt[4]  = mv(mk(0, mfc0(14, 0), 0, 0, 0, 4'hF, 8, 32'h0, 32'hBFC0_0010),         4'hF, 8,     32'h8000_0010, 0, 0,             1);
    vt[5]  = mv(mk(0, mfc0(12, 0), 0, 0, 0, 4'hF, 9, 32'h0, 32'hBFC0_0014),         4'hF, 9,     32'h0040_0000, 0, 0,             1);
    vt[6]  = mv(mk(0, mfc0(14, 1), 0, 0, 0, 4'hF, 9, 32'h0, 32'hBFC0_0018),         4'hF, 9,     32'h0,         0, 0,             1);
    vt[7]  = mv(mk(0, mtc0(8), 0, 0, 0, 4'h0, 0, 32'hDEAD_BEEF, 32'hBFC0_001C),     4'h0, 0,     32'hDEAD_BEEF, 0, 0,             0);
    vt[8]  = mv(mk(0, mfc0(8, 0), 0, 0, 0, 4'hF, 10, 32'h0, 32'hBFC0_0020),         4'hF, 10,    32'h0,         0, 0,             1);
    vt[9]  = mv(mk(32'h8000_0001, NOC0, 1, 1, 5'h04, 4'hF, 11, 32'h5555_5555, 32'hBFC0_0104),
                                                                                    4'h0, 11,    32'h5555_5555, 1, 32'hBFC0_0380, 0);
    vt[10] = mv(mk(0, mfc0(14, 0), 0, 0, 0, 4'hF, 12, 32'h0, 32'hBFC0_0380),        4'hF, 12,    32'hBFC0_0100, 0, 0,             1);
    vt[11] = mv(mk(0, mfc0(8, 0), 0, 0, 0, 4'hF, 12, 32'h0, 32'hBFC0_0384),         4'hF, 12,    32'h8000_0001, 0, 0,             1);
    vt[12] = mv(mk(0, mfc0(12, 0), 0, 0, 0, 4'hF, 12, 32'h0, 32'hBFC0_0388),        4'hF, 12,    32'h0040_0002, 0, 0,             1);
    vt[13] = mv(mk(0, mtc0(14), 0, 0, 0, 4'h0, 0, 32'h8000_0010, 32'hBFC0_038C),    4'h0, 0,     32'h8000_0010, 0, 0,             0);
    vt[14] = mv(mk(32'h0000_0040, NOC0, 0, 1, 5'h05, 4'h0, 0, 32'h0, 32'h8000_1000),
                                                                                    4'h0, 0,     32'h0,         1, 32'hBFC0_0380, 0);
    vt[15] = mv(mk(0, mfc0(14, 0), 0, 0, 0, 4'hF, 13, 32'h0, 32'hBFC0_0390),        4'hF, 13,    32'h8000_0010, 0, 0,             1);
    vt[16] = mv(mk(0, mfc0(8, 0), 0, 0, 0, 4'hF, 13, 32'h0, 32'hBFC0_0394),         4'hF, 13,    32'h0000_0040, 0, 0,             1);
    vt[17] = mv(mk(0, ERET, 0, 0, 0, 4'h0, 0, 32'h0, 32'hBFC0_0398),                4'h0, 0,     32'h0,         1, 32'h8000_0010, 0);
    vt[18] = mv(mk(0, mfc0(12, 0), 0, 0, 0, 4'hF, 14, 32'h0, 32'h8000_0010),        4'hF, 14,    32'h0040_0000, 0, 0,             1);
    vt[19] = mv(mk(0, mtc0(12), 0, 1, 5'h0C, 4'h0, 0, 32'h0000_FF01, 32'h8000_2000),
                                                                                    4'h0, 0,     32'h0000_FF01, 1, 32'hBFC0_0380, 0);
    vt[20] = mv(mk(0, mfc0(12, 0), 0, 0, 0, 4'hF, 15, 32'h0, 32'hBFC0_0400),        4'hF, 15,    32'h0040_0002, 0, 0,             1);
    vt[21] = mv(mk(0, mfc0(14, 0), 0, 0, 0, 4'hF, 15, 32'h0, 32'hBFC0_0404),        4'hF, 15,    32'h8000_2000, 0, 0,             1);
    vt[22] = mv(mk(0, ERET, 0, 1, 5'h08, 4'h0, 0, 32'h0, 32'h8000_3000),            4'h0, 0,     32'h0,         1, 32'hBFC0_0380, 0);
    vt[23] = mv(mk(0, ERET, 0, 0, 0, 4'h0, 0, 32'h0, 32'hBFC0_0408),                4'h0, 0,     32'h0,         1, 32'h8000_2000, 0);
    vt[24] = mv(mk(0, mfc0(12, 0), 0, 0, 0, 4'hF, 16, 32'h0, 32'h8000_2000),        4'hF, 16,    32'h0040_0000, 0, 0,             1);

    resetn         = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    ext_int_in     = 6'd0;
    idle(3);
    chk("rst_flush", 0, {41'd0, flush}, 42'd0);
    chk("rst_rf_we", 0, {38'd0, rf_we}, 42'd0);
    chk("rst_fwd", 0, ws_fwd_bus, 42'd0);
    chk("rst_dbg_pc", 0, {10'd0, debug_wb_pc}, 42'd0);
    chk("rst_has_int", 0, {41'd0, has_int}, 42'd0);
    resetn = 1'b1;
    idle(2);
    chk("allowin", 0, {41'd0, ws_allowin}, 42'd1);
    chk("idle_rf_we", 0, {38'd0, rf_we}, 42'd0);

    for (int i = 0; i < NV; i++) begin
      apply(vt[i].bus);
      chk("rf_we", i, {38'd0, rf_we}, {38'd0, vt[i].we});
      chk("rf_waddr", i, {37'd0, rf_waddr}, {37'd0, vt[i].waddr});
      chk("rf_wdata", i, {10'd0, rf_wdata}, {10'd0, vt[i].wdata});
      chk("flush", i, {41'd0, flush}, {41'd0, vt[i].fl});
      if (vt[i].fl) chk("flush_pc", i, {10'd0, flush_pc}, {10'd0, vt[i].fpc});
      chk("fwd_bus", i, ws_fwd_bus, {vt[i].mf, vt[i].we, vt[i].waddr, vt[i].wdata});
      chk("dbg_pc", i, {10'd0, debug_wb_pc}, {10'd0, vt[i].bus[31:0]});
      chk("dbg_wen", i, {38'd0, debug_wb_rf_wen}, {38'd0, vt[i].we});
      idle(1);
    end

    // Timer interrupt
    do_mtc0(5'd11, 32'd10);
    do_mtc0(5'd12, 32'h0000_8001);
    do_mtc0(5'd9, 32'd0);
    chk("timer_pre", 0, {41'd0, has_int}, 42'd0);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (has_int) begin
        n = k;
        break;
      end
    end
    chk("timer_lat_ok", n, {41'd0, (n == 19 || n == 20)}, 42'd1);
    rd_cp0(5'd13, v32);
    chk("cause_ti_ip7", 0, {40'd0, v32[30], v32[15]}, 42'd3);
    do_mtc0(5'd11, 32'd1000);
    chk("ti_clr_int", 0, {41'd0, has_int}, 42'd0);
    rd_cp0(5'd13, v32);
    chk("cause_ti_clr", 0, {41'd0, v32[30]}, 42'd0);

    // Software IP bits writable, BD/ExcCode not
    do_mtc0(5'd13, 32'hFFFF_FFFF);
    rd_cp0(5'd13, v32);
    chk("cause_sw", 0, {10'd0, v32}, {10'd0, 32'h0000_0320});

    // Hardware interrupt line
    do_mtc0(5'd12, 32'h0000_0401);
    chk("hw_int_off", 0, {41'd0, has_int}, 42'd0);
    ext_int_in = 6'b000001;
    idle(2);
    chk("hw_int_on", 0, {41'd0, has_int}, 42'd1);
    ext_int_in = 6'd0;
    idle(2);
    chk("hw_int_gone", 0, {41'd0, has_int}, 42'd0);

    // Count wrap: exactly one increment over the two edges after the write
    do_mtc0(5'd9, 32'hFFFF_FFFF);
    idle(1);
    apply(mk(32'd0, mfc0(5'd9, 3'd0), 1'b0, 1'b0, 5'd0, 4'hF, 5'd2, 32'd0, 32'hBFC0_3000));
    chk("count_wrap", 0, {10'd0, rf_wdata}, 42'd0);
    idle(1);

    // Asynchronous reset while a flushing instruction sits in WB
    apply(mk(32'h1234_0000, NOC0, 1'b0, 1'b1, 5'h04, 4'hF, 5'd3, 32'd0, 32'h8000_4000));
    chk("pre_rst_flush", 0, {41'd0, flush}, 42'd1);
    resetn = 1'b0;
    #1;
    chk("async_flush", 0, {41'd0, flush}, 42'd0);
    chk("async_rf_we", 0, {38'd0, rf_we}, 42'd0);
    chk("async_dbg_pc", 0, {10'd0, debug_wb_pc}, 42'd0);
    idle(2);
    resetn = 1'b1;
    idle(1);
    rd_cp0(5'd12, v32);
    chk("rst_status", 0, {10'd0, v32}, {10'd0, 32'h0040_0000});
    rd_cp0(5'd14, v32);
    chk("rst_epc", 0, {10'd0, v32}, 42'd0);
    rd_cp0(5'd8, v32);
    chk("rst_badvaddr", 0, {10'd0, v32}, 42'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
